// File: rtl/ika87ad_mc_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: microword field positions,
// bus codes, sequencer states and fixed microcode entry addresses.
package ika87ad_mc_sequencer_pkg;

  localparam int MC_ADDR_W = 8;
  localparam int MC_DATA_W = 18;

  localparam int MC_TYPE_MSB    = 17;
  localparam int MC_TYPE_LSB    = 16;
  localparam int MC_END_BIT     = 15;
  localparam int MC_SKIPCHK_BIT = 14;
  localparam int MC_DECWAIT_BIT = 2;
  localparam int MC_BUS_MSB     = 1;
  localparam int MC_BUS_LSB     = 0;

  // DECWAIT only has meaning in microwords of this type
  localparam logic [1:0] MCTYPE_DEC = 2'd3;

  localparam logic [7:0] MC_IRD_ADDR = 8'hFE;
  localparam logic [7:0] MC_NOP_ADDR = 8'h00;
  localparam logic [7:0] MC_INT_ADDR = 8'hF0;

  typedef enum logic [1:0] {
    BUS_RD3 = 2'd0,
    BUS_RD4 = 2'd1,
    BUS_WR3 = 2'd2,
    BUS_WR4 = 2'd3
  } bus_code_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_LATCH  = 2'd1,
    ST_BWAIT  = 2'd2,
    ST_DECODE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ika87ad_mc_nextaddr.sv
// Next micro-PC selector: decode-wait steps pick interrupt/NOP/decoder entry,
// ordinary steps either return to IRD on END or increment with wrap.
module ika87ad_mc_nextaddr
  import ika87ad_mc_sequencer_pkg::*;
#(
  parameter int               ADDR_W   = MC_ADDR_W,
  parameter logic [ADDR_W-1:0] IRD_ADDR = ADDR_W'(MC_IRD_ADDR),
  parameter logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(MC_NOP_ADDR),
  parameter logic [ADDR_W-1:0] INT_ADDR = ADDR_W'(MC_INT_ADDR)
) (
  input  logic              mc_end,
  input  logic              dec_wait,
  input  logic              skip,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] dec_entry,
  input  logic [ADDR_W-1:0] upc,
  output logic [ADDR_W-1:0] upc_next
);

  always_comb begin
    upc_next = upc + ADDR_W'(1);
    if (dec_wait) begin
      // interrupt outranks skip; both discard the decoder entry
      if (int_req)   upc_next = INT_ADDR;
      else if (skip) upc_next = NOP_ADDR;
      else           upc_next = dec_entry;
    end else if (mc_end) begin
      upc_next = IRD_ADDR;
    end
  end

endmodule

// File: rtl/ika87ad_mc_sequencer.sv
// Microcode sequencer between the microcode ROM and the datapath.
// Optional interrupt entry is enabled by defining IKA87AD_SEQ_INT_EN.
//
// state  | meaning
// FETCH  | drive ROM address = micro-PC, pulse read tick
// LATCH  | capture microword, exec strobe, issue bus request
// BWAIT  | wait for bus done, then step or return to IRD
// DECODE | wait for bus done and decoder entry (any order), then jump
module ika87ad_mc_sequencer
  import ika87ad_mc_sequencer_pkg::*;
#(
  parameter int               ADDR_W   = MC_ADDR_W,
  parameter int               DATA_W   = MC_DATA_W,
  parameter logic [ADDR_W-1:0] IRD_ADDR = ADDR_W'(MC_IRD_ADDR),
  parameter logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(MC_NOP_ADDR),
  parameter logic [ADDR_W-1:0] INT_ADDR = ADDR_W'(MC_INT_ADDR)
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_CEN,
  output logic              o_MCROM_READ_TICK,
  output logic [ADDR_W-1:0] o_MCROM_ADDR,
  input  logic [DATA_W-1:0] i_MCROM_DATA,
  output logic [DATA_W-1:0] o_MC,
  output logic              o_MC_EXEC,
  output logic              o_BUS_REQ,
  output logic [1:0]        o_BUS_CODE,
  input  logic              i_BUS_DONE,
  input  logic              i_DEC_VALID,
  input  logic [ADDR_W-1:0] i_DEC_ENTRY,
  input  logic              i_SKIP,
  output logic              o_SKIP_CLR,
  output logic              o_INSTR_END
`ifdef IKA87AD_SEQ_INT_EN
  ,
  input  logic              i_INT_REQ,
  output logic              o_INT_ACK
`endif
);

  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] upc, upc_step;
  logic              done_seen, dec_seen;
  logic              run, done_any, dec_any, ld_upc;
  logic              data_decwait, mc_end, int_req;

  // pulses are gated by reset as well so nothing fires while held in reset
  assign run          = i_CEN & ~i_RST;
  assign done_any     = done_seen | i_BUS_DONE;
  assign dec_any      = dec_seen | i_DEC_VALID;
  assign mc_end       = o_MC[MC_END_BIT];
  assign data_decwait = (i_MCROM_DATA[MC_TYPE_MSB:MC_TYPE_LSB] == MCTYPE_DEC) &&
                        i_MCROM_DATA[MC_DECWAIT_BIT];

`ifdef IKA87AD_SEQ_INT_EN
  assign int_req   = i_INT_REQ;
  assign o_INT_ACK = ld_upc && (state == ST_DECODE) && i_INT_REQ;
`else
  assign int_req   = 1'b0;
`endif

  assign o_MCROM_ADDR = upc;
  assign o_BUS_CODE   = (state == ST_LATCH) ? i_MCROM_DATA[MC_BUS_MSB:MC_BUS_LSB]
                                            : o_MC[MC_BUS_MSB:MC_BUS_LSB];

  ika87ad_mc_nextaddr #(
    .ADDR_W   (ADDR_W),
    .IRD_ADDR (IRD_ADDR),
    .NOP_ADDR (NOP_ADDR),
    .INT_ADDR (INT_ADDR)
  ) u_nextaddr (
    .mc_end    (mc_end),
    .dec_wait  (state == ST_DECODE),
    .skip      (i_SKIP),
    .int_req   (int_req),
    .dec_entry (i_DEC_ENTRY),
    .upc       (upc),
    .upc_next  (upc_step)
  );

  always_comb begin
    state_nxt         = state;
    o_MCROM_READ_TICK = 1'b0;
    o_MC_EXEC         = 1'b0;
    o_BUS_REQ         = 1'b0;
    o_SKIP_CLR        = 1'b0;
    o_INSTR_END       = 1'b0;
    ld_upc            = 1'b0;
    case (state)
      ST_FETCH: begin
        o_MCROM_READ_TICK = run;
        if (run) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        o_MC_EXEC = run;
        o_BUS_REQ = run;
        if (run) state_nxt = data_decwait ? ST_DECODE : ST_BWAIT;
      end
      ST_BWAIT: begin
        if (run && i_BUS_DONE) begin
          ld_upc      = 1'b1;
          o_INSTR_END = mc_end;
          state_nxt   = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (run && done_any && dec_any) begin
          ld_upc     = 1'b1;
          o_SKIP_CLR = i_SKIP & ~int_req;
          state_nxt  = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= ST_FETCH;
      upc       <= IRD_ADDR;
      o_MC      <= '0;
      done_seen <= 1'b0;
      dec_seen  <= 1'b0;
    end else if (i_CEN) begin
      state <= state_nxt;
      if (ld_upc) upc <= upc_step;
      if (state == ST_LATCH) o_MC <= i_MCROM_DATA;
      if ((state == ST_DECODE) && !ld_upc) begin
        done_seen <= done_any;
        dec_seen  <= dec_any;
      end else begin
        done_seen <= 1'b0;
        dec_seen  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ika87ad_mc_sequencer.sv
// Directed bench for ika87ad_mc_sequencer with a small ROM, bus and decoder model.
`timescale 1ns/1ps
module tb_ika87ad_mc_sequencer;
  import ika87ad_mc_sequencer_pkg::*;

  logic        i_CLK = 1'b0;
  logic        i_RST, i_CEN, i_BUS_DONE, i_DEC_VALID, i_SKIP;
  logic [7:0]  i_DEC_ENTRY;
  logic [17:0] i_MCROM_DATA;
  logic        o_MCROM_READ_TICK, o_MC_EXEC, o_BUS_REQ, o_SKIP_CLR, o_INSTR_END;
  logic [7:0]  o_MCROM_ADDR;
  logic [17:0] o_MC;
  logic [1:0]  o_BUS_CODE;
`ifdef IKA87AD_SEQ_INT_EN
  logic        i_INT_REQ, o_INT_ACK;
`endif

  ika87ad_mc_sequencer dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CEN(i_CEN),
    .o_MCROM_READ_TICK(o_MCROM_READ_TICK), .o_MCROM_ADDR(o_MCROM_ADDR),
    .i_MCROM_DATA(i_MCROM_DATA), .o_MC(o_MC), .o_MC_EXEC(o_MC_EXEC),
    .o_BUS_REQ(o_BUS_REQ), .o_BUS_CODE(o_BUS_CODE), .i_BUS_DONE(i_BUS_DONE),
    .i_DEC_VALID(i_DEC_VALID), .i_DEC_ENTRY(i_DEC_ENTRY), .i_SKIP(i_SKIP),
    .o_SKIP_CLR(o_SKIP_CLR), .o_INSTR_END(o_INSTR_END)
`ifdef IKA87AD_SEQ_INT_EN
    , .i_INT_REQ(i_INT_REQ), .o_INT_ACK(o_INT_ACK)
`endif
  );

  always #5 i_CLK = ~i_CLK;

  // ROM: FE = decode-wait RD4, 10 = WR3, 11 = RD4+END, 00 = NOP (END), F0 = int entry
  logic [17:0] rom [256];
  logic [17:0] rom_q = 18'h0;
  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 18'h08000;
    rom[8'hFE] = 18'h30005;
    rom[8'h10] = 18'h00002;
    rom[8'h11] = 18'h08001;
    rom[8'h00] = 18'h08000;
    rom[8'hF0] = 18'h08003;
  end
  always @(posedge i_CLK) if (o_MCROM_READ_TICK) rom_q <= rom[o_MCROM_ADDR];
  assign i_MCROM_DATA = rom_q;

  int n_vec = 0, n_miss = 0;

  // knobs written by the tests, read by the environment model
  int bus_lat = 0, dec_lat = 0;
  bit cen_toggle = 0, skip_arm = 0;

  // logs written by the environment model, cleared while reset is held
  logic [7:0] tick_q[$];
  int tick_cyc[$];
  int cyc = 0, req_cnt = 0, exec_cnt = 0, end_cnt = 0, end_at = -1, skclr_cnt = 0;
  int intack_cnt = 0, overlap = 0, addr_err = 0, tick_busy = 0;
  bit busy = 0, dec_arm = 0, nxt_done = 0, nxt_dec = 0, nxt_cen = 1, nxt_skip = 0;
  int bus_cnt = 0, dec_cnt = 0;
  logic [7:0] req_addr = 8'h0;

  initial begin : env_model
    i_CEN = 1'b1; i_BUS_DONE = 1'b0; i_DEC_VALID = 1'b0; i_SKIP = 1'b0;
    forever begin
      @(negedge i_CLK);
      cyc++;
      if (i_RST) begin
        tick_q.delete(); tick_cyc.delete();
        req_cnt = 0; exec_cnt = 0; end_cnt = 0; end_at = -1; skclr_cnt = 0;
        intack_cnt = 0; overlap = 0; addr_err = 0; tick_busy = 0;
        busy = 0; dec_arm = 0; bus_cnt = 0; dec_cnt = 0;
        nxt_done = 0; nxt_dec = 0; nxt_cen = 1; nxt_skip = skip_arm;
      end else begin
        if (busy && o_MCROM_ADDR !== req_addr) addr_err++;
        if (busy && o_MCROM_READ_TICK) tick_busy++;
        if (o_MCROM_READ_TICK) begin
          tick_q.push_back(o_MCROM_ADDR); tick_cyc.push_back(cyc);
          dec_arm = 0;
        end
        if (o_INSTR_END) begin end_cnt++; end_at = tick_q.size(); end
        if (o_SKIP_CLR) skclr_cnt++;
`ifdef IKA87AD_SEQ_INT_EN
        if (o_INT_ACK) intack_cnt++;
`endif
        if (i_BUS_DONE && i_CEN) busy = 0;
        if (o_BUS_REQ) begin
          if (busy) overlap++;
          req_cnt++; busy = 1; bus_cnt = bus_lat; req_addr = o_MCROM_ADDR;
        end else if (busy && i_CEN && bus_cnt > 0) bus_cnt--;
        nxt_done = busy && (bus_cnt == 0);
        if (o_MC_EXEC) begin
          exec_cnt++;
          if (o_MCROM_ADDR == MC_IRD_ADDR) begin dec_arm = 1; dec_cnt = dec_lat; end
        end else if (dec_arm && i_CEN && dec_cnt > 0) dec_cnt--;
        nxt_dec  = dec_arm && (dec_cnt == 0);
        nxt_cen  = cen_toggle ? ~i_CEN : 1'b1;
        nxt_skip = skip_arm && (skclr_cnt == 0);
      end
      @(posedge i_CLK); #1;
      i_BUS_DONE = nxt_done; i_DEC_VALID = nxt_dec; i_CEN = nxt_cen; i_SKIP = nxt_skip;
    end
  end

  task automatic do_reset();
    @(posedge i_CLK); #1; i_RST = 1'b1;
    repeat (2) @(posedge i_CLK);
    #1; i_RST = 1'b0;
  endtask

  task automatic wait_ticks(input int n, input int budget, output bit ok);
    int k = 0;
    while (tick_q.size() < n && k < budget) begin @(posedge i_CLK); k++; end
    ok = (tick_q.size() >= n);
  endtask

  task automatic test_reset();
    bus_lat = 0; dec_lat = 0; cen_toggle = 0; skip_arm = 0;
    @(posedge i_CLK); #1; i_RST = 1'b1;
    @(negedge i_CLK);
    n_vec++; if ({o_MCROM_READ_TICK, o_MC_EXEC, o_BUS_REQ, o_SKIP_CLR, o_INSTR_END} !== 5'b0) begin
      n_miss++; $display("FAIL reset_pulses: got %b expected 00000",
        {o_MCROM_READ_TICK, o_MC_EXEC, o_BUS_REQ, o_SKIP_CLR, o_INSTR_END}); end
    n_vec++; if (o_MC !== 18'h0) begin n_miss++; $display("FAIL reset_mc: got %h expected 0", o_MC); end
    n_vec++; if (o_BUS_CODE !== 2'b00) begin n_miss++; $display("FAIL reset_code: got %b expected 00", o_BUS_CODE); end
    n_vec++; if (o_MCROM_ADDR !== 8'hFE) begin n_miss++; $display("FAIL reset_addr: got %h expected fe", o_MCROM_ADDR); end
    @(posedge i_CLK); #1; i_RST = 1'b0;
    @(negedge i_CLK);
    n_vec++; if (o_MCROM_READ_TICK !== 1'b1 || o_MCROM_ADDR !== 8'hFE) begin
      n_miss++; $display("FAIL first_fetch: tick=%b addr=%h expected tick=1 addr=fe", o_MCROM_READ_TICK, o_MCROM_ADDR); end
    @(negedge i_CLK);
    n_vec++; if (o_BUS_REQ !== 1'b1 || o_MC_EXEC !== 1'b1 || o_BUS_CODE !== BUS_RD4 || o_MCROM_READ_TICK !== 1'b0) begin
      n_miss++; $display("FAIL first_latch: req=%b exec=%b code=%b tick=%b expected 1 1 01 0",
        o_BUS_REQ, o_MC_EXEC, o_BUS_CODE, o_MCROM_READ_TICK); end
    @(negedge i_CLK);
    n_vec++; if (o_MC !== 18'h30005 || o_BUS_REQ !== 1'b0) begin
      n_miss++; $display("FAIL first_mc: mc=%h req=%b expected 30005 0", o_MC, o_BUS_REQ); end
  endtask

  task automatic test_mvi();
    logic [7:0] exp_a [4] = '{8'hFE, 8'h10, 8'h11, 8'hFE};
    bit ok;
    bus_lat = 0; dec_lat = 0; cen_toggle = 0; skip_arm = 0; i_DEC_ENTRY = 8'h10;
    do_reset();
    wait_ticks(4, 100, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL mvi_timeout: got %0d ticks expected 4", tick_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (tick_q[i] !== exp_a[i]) begin
          n_miss++; $display("FAIL mvi_addr[%0d]: got %h expected %h", i, tick_q[i], exp_a[i]); end
      end
      n_vec++; if (tick_cyc[2] - tick_cyc[1] != 3) begin
        n_miss++; $display("FAIL mvi_min_step: got %0d cycles expected 3", tick_cyc[2] - tick_cyc[1]); end
    end
    n_vec++; if (end_cnt !== 1 || end_at !== 3) begin
      n_miss++; $display("FAIL mvi_instr_end: count=%0d after_tick=%0d expected 1 3", end_cnt, end_at); end
    n_vec++; if (req_cnt !== 3 || exec_cnt !== 3 || overlap !== 0) begin
      n_miss++; $display("FAIL mvi_req: req=%0d exec=%0d overlap=%0d expected 3 3 0", req_cnt, exec_cnt, overlap); end
  endtask

  task automatic test_bus_wait();
    logic [7:0] exp_a [4] = '{8'hFE, 8'h10, 8'h11, 8'hFE};
    bit ok;
    bus_lat = 5; dec_lat = 0; cen_toggle = 0; skip_arm = 0; i_DEC_ENTRY = 8'h10;
    do_reset();
    wait_ticks(4, 200, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL bwait_timeout: got %0d ticks expected 4", tick_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (tick_q[i] !== exp_a[i]) begin
          n_miss++; $display("FAIL bwait_addr[%0d]: got %h expected %h", i, tick_q[i], exp_a[i]); end
      end
      n_vec++; if (tick_cyc[2] - tick_cyc[1] != 8) begin
        n_miss++; $display("FAIL bwait_step: got %0d cycles expected 8", tick_cyc[2] - tick_cyc[1]); end
    end
    n_vec++; if (req_cnt !== 3 || addr_err !== 0 || tick_busy !== 0) begin
      n_miss++; $display("FAIL bwait_hold: req=%0d addr_moves=%0d ticks_busy=%0d expected 3 0 0",
        req_cnt, addr_err, tick_busy); end
  endtask

  task automatic test_skip();
    logic [7:0] exp_a [3] = '{8'hFE, 8'h00, 8'hFE};
    bit ok;
    bus_lat = 0; dec_lat = 0; cen_toggle = 0; skip_arm = 1; i_DEC_ENTRY = 8'h10;
    do_reset();
    wait_ticks(3, 100, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL skip_timeout: got %0d ticks expected 3", tick_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (tick_q[i] !== exp_a[i]) begin
          n_miss++; $display("FAIL skip_addr[%0d]: got %h expected %h", i, tick_q[i], exp_a[i]); end
      end
    end
    n_vec++; if (skclr_cnt !== 1 || end_cnt !== 1 || end_at !== 2) begin
      n_miss++; $display("FAIL skip_pulses: skip_clr=%0d end=%0d end_after=%0d expected 1 1 2",
        skclr_cnt, end_cnt, end_at); end
    skip_arm = 0;
  endtask

  task automatic test_dec_order();
    int cfg [3][3] = '{'{3, 0, 6}, '{0, 0, 3}, '{0, 3, 6}};
    logic [7:0] exp_a [4] = '{8'hFE, 8'h10, 8'h11, 8'hFE};
    bit ok;
    cen_toggle = 0; skip_arm = 0; i_DEC_ENTRY = 8'h10;
    for (int r = 0; r < 3; r++) begin
      bus_lat = cfg[r][0]; dec_lat = cfg[r][1];
      do_reset();
      wait_ticks(4, 200, ok);
      n_vec++;
      if (!ok) begin n_miss++; $display("FAIL order%0d_timeout: got %0d ticks expected 4", r, tick_q.size()); end
      else begin
        for (int i = 0; i < 4; i++) begin
          n_vec++; if (tick_q[i] !== exp_a[i]) begin
            n_miss++; $display("FAIL order%0d_addr[%0d]: got %h expected %h", r, i, tick_q[i], exp_a[i]); end
        end
        n_vec++; if (tick_cyc[1] - tick_cyc[0] != cfg[r][2]) begin
          n_miss++; $display("FAIL order%0d_decode_len: got %0d expected %0d", r, tick_cyc[1] - tick_cyc[0], cfg[r][2]); end
      end
    end
  endtask

  task automatic test_cen();
    logic [7:0] exp_a [4] = '{8'hFE, 8'h10, 8'h11, 8'hFE};
    bit ok;
    bus_lat = 0; dec_lat = 0; cen_toggle = 1; skip_arm = 0; i_DEC_ENTRY = 8'h10;
    do_reset();
    wait_ticks(4, 200, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL cen_timeout: got %0d ticks expected 4", tick_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (tick_q[i] !== exp_a[i]) begin
          n_miss++; $display("FAIL cen_addr[%0d]: got %h expected %h", i, tick_q[i], exp_a[i]); end
      end
      n_vec++; if (tick_cyc[1] - tick_cyc[0] != 6 || tick_cyc[2] - tick_cyc[1] != 6) begin
        n_miss++; $display("FAIL cen_stretch: got %0d %0d cycles expected 6 6",
          tick_cyc[1] - tick_cyc[0], tick_cyc[2] - tick_cyc[1]); end
    end
    n_vec++; if (req_cnt !== 3 || exec_cnt !== 3 || end_cnt !== 1) begin
      n_miss++; $display("FAIL cen_pulses: req=%0d exec=%0d end=%0d expected 3 3 1", req_cnt, exec_cnt, end_cnt); end
    cen_toggle = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus_lat = 5; dec_lat = 0; cen_toggle = 0; skip_arm = 0; i_DEC_ENTRY = 8'h10;
    do_reset();
    wait_ticks(3, 200, ok);
    repeat (2) @(posedge i_CLK);
    n_vec++; if (!ok || req_cnt !== 3 || o_MCROM_ADDR !== 8'h11) begin
      n_miss++; $display("FAIL midrst_setup: ticks=%0d req=%0d addr=%h expected 3 3 11",
        tick_q.size(), req_cnt, o_MCROM_ADDR); end
    #1; i_RST = 1'b1;
    @(negedge i_CLK);
    n_vec++; if ({o_MCROM_READ_TICK, o_MC_EXEC, o_BUS_REQ, o_INSTR_END} !== 4'b0 ||
                 o_MC !== 18'h0 || o_BUS_CODE !== 2'b00 || o_MCROM_ADDR !== 8'hFE) begin
      n_miss++; $display("FAIL midrst_zero: pulses=%b mc=%h code=%b addr=%h expected 0000 0 00 fe",
        {o_MCROM_READ_TICK, o_MC_EXEC, o_BUS_REQ, o_INSTR_END}, o_MC, o_BUS_CODE, o_MCROM_ADDR); end
    bus_lat = 0;
    @(posedge i_CLK); #1; i_RST = 1'b0;
    wait_ticks(2, 100, ok);
    n_vec++; if (!ok) begin n_miss++; $display("FAIL midrst_timeout: got %0d ticks expected 2", tick_q.size()); end
    else if (tick_q[0] !== 8'hFE || tick_q[1] !== 8'h10) begin
      n_miss++; $display("FAIL midrst_restart: got %h %h expected fe 10", tick_q[0], tick_q[1]); end
  endtask

`ifdef IKA87AD_SEQ_INT_EN
  task automatic test_int();
    logic [7:0] exp_a [3] = '{8'hFE, 8'hF0, 8'hFE};
    bit ok;
    bus_lat = 0; dec_lat = 0; cen_toggle = 0; skip_arm = 1; i_DEC_ENTRY = 8'h10; i_INT_REQ = 1'b1;
    do_reset();
    wait_ticks(3, 100, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL int_timeout: got %0d ticks expected 3", tick_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (tick_q[i] !== exp_a[i]) begin
          n_miss++; $display("FAIL int_addr[%0d]: got %h expected %h", i, tick_q[i], exp_a[i]); end
      end
    end
    n_vec++; if (intack_cnt !== 1 || skclr_cnt !== 0) begin
      n_miss++; $display("FAIL int_pulses: ack=%0d skip_clr=%0d expected 1 0", intack_cnt, skclr_cnt); end
    i_INT_REQ = 1'b0; skip_arm = 0;
  endtask
`endif

  initial begin : main
    i_RST = 1'b0;
    i_DEC_ENTRY = 8'h10;
`ifdef IKA87AD_SEQ_INT_EN
    i_INT_REQ = 1'b0;
`endif
    test_reset();
    test_mvi();
    test_bus_wait();
    test_skip();
    test_dec_order();
    test_cen();
    test_reset_mid();
`ifdef IKA87AD_SEQ_INT_EN
    test_int();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
